// File: rtl/ssd_pkg.sv
// Shared types and seven-segment constants for the sequence display/entry stage.
// Pure declarations: no latency, no flow control.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ENTRY,
        ST_DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0100001;

    // Active-low segment patterns for symbol indices 0..7.
    localparam logic [6:0] SEG_SYM [8] = '{
        7'b1111110, 7'b1111001, 7'b1110111, 7'b1001111,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000
    };

    function automatic logic [6:0] seg_of(input logic [7:0] idx, input int num_syms);
        if (int'(idx) >= num_syms) begin
            return SEG_ERR;
        end
        return SEG_SYM[idx[2:0]];
    endfunction

endpackage

// File: rtl/ssd_btn_edge.sv
// Rising-edge detector for one debounced button level.
// Pulse is combinational from the input against a registered history; no backpressure.
module ssd_btn_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/ssd_sequence_entry.sv
// Shows a target symbol sequence, then lets the player re-enter it with move/next buttons.
// All outputs registered (one cycle after the deciding edge); buttons act on rising edges only.
module ssd_sequence_entry
    import ssd_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter int          NUM_SYMS   = 4,
    parameter int          SYM_W      = 2,
    parameter int          SHOW_SECS  = 2,
    parameter logic [7:0]  START_CODE = 8'h10
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic [7:0]                                 i_display,
    input  logic                                       i_one_sec,
    input  logic                                       i_button_move,
    input  logic                                       i_button_next,
    input  logic [NUM_DIGITS*SYM_W-1:0]                i_sequence_in,
    output logic [NUM_DIGITS*SYM_W-1:0]                o_sequence_out,
    output logic [NUM_DIGITS*7-1:0]                    o_sevseg,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] o_cursor,
    output logic                                       o_entry_done,
    output logic                                       o_match
);

    localparam int SEQ_W = NUM_DIGITS * SYM_W;
    localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [SEQ_W-1:0]   r_target, w_target_nxt;
    logic [SEQ_W-1:0]   r_entered, w_entered_nxt;
    logic [CUR_W-1:0]   r_cursor, w_cursor_nxt;
    logic [SEQ_W-1:0]   r_seq_out;
    logic [NUM_DIGITS*7-1:0] r_sevseg, w_sevseg_nxt;
    logic               r_done, r_match;
    logic               w_move_rise, w_next_rise, w_start, w_tgt_ok;
    logic [SYM_W-1:0]   w_dig_cur;

    ssd_btn_edge u_move (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_button_move), .o_rise(w_move_rise));
    ssd_btn_edge u_next (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_button_next), .o_rise(w_next_rise));

    assign w_start   = (i_display == START_CODE);
    assign w_dig_cur = r_entered[r_cursor*SYM_W +: SYM_W];

    // A target holding an unrepresentable symbol can never be matched.
    always_comb begin
        w_tgt_ok = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(r_target[k*SYM_W +: SYM_W]) >= NUM_SYMS) begin
                w_tgt_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_target_nxt  = r_target;
        w_entered_nxt = r_entered;
        w_cursor_nxt  = r_cursor;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_SHOW;
                    w_target_nxt = i_sequence_in;
                    w_cnt_nxt    = 4'd0;
                end
            end
            ST_SHOW: begin
                if (!w_start) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_one_sec) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (w_cnt_nxt == 4'(SHOW_SECS)) begin
                        w_state_nxt   = ST_ENTRY;
                        w_entered_nxt = '0;
                        w_cursor_nxt  = '0;
                    end
                end
            end
            ST_ENTRY: begin
                if (!w_start) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_next_rise) begin
                    if (r_cursor == CUR_W'(NUM_DIGITS - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cursor_nxt = r_cursor + 1'b1;
                    end
                end else if (w_move_rise) begin
                    w_entered_nxt[r_cursor*SYM_W +: SYM_W] =
                        (w_dig_cur >= SYM_W'(NUM_SYMS - 1)) ? '0 : w_dig_cur + 1'b1;
                end
            end
            ST_DONE: begin
                if (!w_start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Segments are looked up from next-cycle values so the display tracks the registered state.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg
        logic [SYM_W-1:0] w_sym;
        assign w_sym = (w_state_nxt == ST_SHOW) ? w_target_nxt[k*SYM_W +: SYM_W]
                                                : w_entered_nxt[k*SYM_W +: SYM_W];
        assign w_sevseg_nxt[k*7 +: 7] = (w_state_nxt == ST_IDLE) ? SEG_BLANK
                                                                 : seg_of(8'(w_sym), NUM_SYMS);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt     <= 4'd0;
            r_target  <= '0;
            r_entered <= '0;
            r_cursor  <= '0;
            r_seq_out <= '0;
            r_sevseg  <= '1;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_target  <= w_target_nxt;
            r_entered <= w_entered_nxt;
            r_cursor  <= w_cursor_nxt;
            r_sevseg  <= w_sevseg_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE) begin
                r_seq_out <= w_entered_nxt;
                r_match   <= (w_entered_nxt == r_target) && w_tgt_ok;
            end else begin
                r_match   <= 1'b0;
            end
        end
    end

    assign o_sequence_out = r_seq_out;
    assign o_sevseg       = r_sevseg;
    assign o_cursor       = r_cursor;
    assign o_entry_done   = r_done;
    assign o_match        = r_match;

endmodule

// File: tb/tb_ssd_sequence_entry.sv
// Directed bench for ssd_sequence_entry: default instance plus a NUM_SYMS=3 instance.
module tb_ssd_sequence_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] display;
    logic       one_sec, mv, nx;
    logic [7:0] seq_in;

    logic [7:0]  seq_out,  seq_out3;
    logic [27:0] sevseg,   sevseg3;
    logic [1:0]  cursor,   cursor3;
    logic        done,     done3;
    logic        match,    match3;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int btn;   // 1 = move, 2 = next, 3 = both
        int cur;
        int d3, d2, d1, d0;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    ssd_sequence_entry dut (
        .i_clk(clk), .i_reset(rst_n), .i_display(display), .i_one_sec(one_sec),
        .i_button_move(mv), .i_button_next(nx), .i_sequence_in(seq_in),
        .o_sequence_out(seq_out), .o_sevseg(sevseg), .o_cursor(cursor),
        .o_entry_done(done), .o_match(match)
    );

    ssd_sequence_entry #(.NUM_SYMS(3)) dut3 (
        .i_clk(clk), .i_reset(rst_n), .i_display(display), .i_one_sec(one_sec),
        .i_button_move(mv), .i_button_next(nx), .i_sequence_in(seq_in),
        .o_sequence_out(seq_out3), .o_sevseg(sevseg3), .o_cursor(cursor3),
        .o_entry_done(done3), .o_match(match3)
    );

    function automatic logic [6:0] segb(input int s);
        case (s)
            0:       return 7'b1111110;
            1:       return 7'b1111001;
            2:       return 7'b1110111;
            3:       return 7'b1001111;
            default: return 7'b0100001;
        endcase
    endfunction

    function automatic logic [27:0] sv4(input int d3, input int d2, input int d1, input int d0);
        return {segb(d3), segb(d2), segb(d1), segb(d0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        one_sec = 1'b1;
        step();
        one_sec = 1'b0;
    endtask

    task automatic press(input int btn);
        mv = (btn == 1 || btn == 3);
        nx = (btn == 2 || btn == 3);
        step();
        mv = 1'b0;
        nx = 1'b0;
        step();
    endtask

    task automatic start_round(input logic [7:0] s);
        display = 8'h10;
        seq_in  = s;
        step();
        pulse();
        pulse();
    endtask

    initial begin
        rst_n = 1'b1; display = 8'h00; one_sec = 1'b0; mv = 1'b0; nx = 1'b0; seq_in = 8'h00;
        tbl[0] = '{2, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 1, 0};
        tbl[2] = '{2, 2, 0, 0, 1, 0};
        tbl[3] = '{1, 2, 0, 1, 1, 0};
        tbl[4] = '{1, 2, 0, 2, 1, 0};
        tbl[5] = '{2, 3, 0, 2, 1, 0};
        tbl[6] = '{1, 3, 1, 2, 1, 0};
        tbl[7] = '{1, 3, 2, 2, 1, 0};
        tbl[8] = '{1, 3, 3, 2, 1, 0};

        #2 rst_n = 1'b0;
        #2;
        check("rst_sevseg", sevseg, 28'hFFFFFFF);
        check("rst_seq_out", seq_out, 8'h00);
        check("rst_cursor", cursor, 2'd0);
        check("rst_done", done, 1'b0);
        check("rst_match", match, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Show phase, target latched, input changes ignored
        display = 8'h10; seq_in = 8'hE4;
        step();
        check("show_digits", sevseg, sv4(3, 2, 1, 0));
        seq_in = 8'h00;
        pulse();
        check("show_hold", sevseg, sv4(3, 2, 1, 0));
        check("show_not_done", done, 1'b0);
        pulse();
        check("entry_first_seg", sevseg, sv4(0, 0, 0, 0));
        check("entry_first_cur", cursor, 2'd0);

        // Full correct entry
        for (int i = 0; i < 9; i++) begin
            press(tbl[i].btn);
            check($sformatf("tbl%0d_cursor", i), cursor, 64'(tbl[i].cur));
            check($sformatf("tbl%0d_sevseg", i), sevseg, sv4(tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0));
        end
        press(2);
        check("done_flag", done, 1'b1);
        check("done_match", match, 1'b1);
        check("done_seq_out", seq_out, 8'hE4);
        check("done_seg_hold", sevseg, sv4(3, 2, 1, 0));
        display = 8'h00;
        step();
        check("leave_done", done, 1'b0);
        check("leave_match", match, 1'b0);
        check("leave_seq_hold", seq_out, 8'hE4);
        check("leave_blank", sevseg, 28'hFFFFFFF);

        // Wrap and held button
        start_round(8'hE4);
        repeat (5) press(1);
        check("wrap_5_moves", sevseg, sv4(0, 0, 0, 1));
        mv = 1'b1;
        repeat (20) step();
        mv = 1'b0;
        step();
        check("held_once", sevseg, sv4(0, 0, 0, 2));
        press(2);
        press(2);
        check("cursor_two", cursor, 2'd2);
        press(3);
        check("both_cursor", cursor, 2'd3);
        check("both_digit_kept", sevseg, sv4(0, 0, 0, 2));
        press(2);
        check("bad_done", done, 1'b1);
        check("bad_match", match, 1'b0);
        check("bad_seq_out", seq_out, 8'h02);

        // Out-of-range symbol in the NUM_SYMS=3 instance
        display = 8'h00;
        step();
        display = 8'h10; seq_in = 8'h9C;
        step();
        check("err_seg3", sevseg3, sv4(2, 1, -1, 0));
        check("sym3_seg4", sevseg, sv4(2, 1, 3, 0));
        pulse();
        pulse();
        press(2); press(2); press(1); press(2); press(1); press(1); press(2);
        check("err_done3", done3, 1'b1);
        check("err_match3", match3, 1'b0);
        check("err_seq_out3", seq_out3, 8'h90);
        check("mis_match4", match, 1'b0);

        // Abort mid-entry, then reset during show
        display = 8'h00;
        step();
        start_round(8'hE4);
        press(1);
        display = 8'h00;
        step();
        check("abort_blank", sevseg, 28'hFFFFFFF);
        check("abort_done", done, 1'b0);
        display = 8'h10;
        step();
        check("reshow", sevseg, sv4(3, 2, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sevseg", sevseg, 28'hFFFFFFF);
        check("mid_rst_seq_out", seq_out, 8'h00);
        check("mid_rst_cursor", cursor, 2'd0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_match", match, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
